// File: rtl/gain_collector_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// gain_collector_pkg : FSM state encoding and default derived widths
// Rev 1.0
//------------------------------------------------------------------------------
package gain_collector_pkg;

  localparam int NI_W   = 1;
  localparam int NB_W   = 1;
  localparam int INT_W  = 4;
  localparam int BOOL_W = 1;
  localparam int NC_W   = 2;

  localparam int NI = 1 << NI_W;
  localparam int NB = 1 << NB_W;
  localparam int NC = 1 << NC_W;
  localparam int GW = NC_W + 1;
  localparam int IW = INT_W * NI;
  localparam int BW = BOOL_W * NB;
  localparam int T  = NB + NI;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_COLLECT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/gain_collector_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// gain_collector_if : candidate handshake plus serial clause-result beats
// Rev 1.0
//------------------------------------------------------------------------------
interface gain_collector_if
  import gain_collector_pkg::*;
#(
  parameter int EVAL_IW = IW,
  parameter int EVAL_BW = BW
) ();

  logic               eval_valid;
  logic               eval_ready;
  logic [EVAL_IW-1:0] eval_integer_assignment;
  logic [EVAL_BW-1:0] eval_boolean_assignment;
  logic               clause_valid;
  logic               clause_satisfied;

  modport master (
    output eval_valid,
    output eval_integer_assignment,
    output eval_boolean_assignment,
    input  eval_ready,
    input  clause_valid,
    input  clause_satisfied
  );

  modport slave (
    input  eval_valid,
    input  eval_integer_assignment,
    input  eval_boolean_assignment,
    output eval_ready,
    output clause_valid,
    output clause_satisfied
  );

endinterface
`default_nettype wire

// File: rtl/gain_collector_candidate_builder.sv
`default_nettype none
//------------------------------------------------------------------------------
// gain_collector_candidate_builder : maps candidate index k to its assignment
// Rev 1.0
//------------------------------------------------------------------------------
module gain_collector_candidate_builder
  import gain_collector_pkg::*;
#(
  parameter int NUM_BOOL   = NB,
  parameter int NUM_INT    = NI,
  parameter int INT_WIDTH  = INT_W,
  parameter int BOOL_WIDTH = BOOL_W,
  parameter int KW         = $clog2(T)
) (
  input  wire logic [KW-1:0]                   k,
  input  wire logic [NUM_INT*INT_WIDTH-1:0]    current_integer,
  input  wire logic [NUM_BOOL*BOOL_WIDTH-1:0]  current_boolean,
  input  wire logic [NUM_INT*INT_WIDTH-1:0]    proposals,
  output logic      [NUM_INT*INT_WIDTH-1:0]    candidate_integer,
  output logic      [NUM_BOOL*BOOL_WIDTH-1:0]  candidate_boolean
);

  // Candidates 0..NB-1 flip one boolean; NB..T-1 take one integer proposal.
  for (genvar b = 0; b < NUM_BOOL; b++) begin : g_bool
    assign candidate_boolean[b*BOOL_WIDTH +: BOOL_WIDTH] =
      (k == KW'(b)) ? ~current_boolean[b*BOOL_WIDTH +: BOOL_WIDTH]
                    :  current_boolean[b*BOOL_WIDTH +: BOOL_WIDTH];
  end

  for (genvar i = 0; i < NUM_INT; i++) begin : g_int
    assign candidate_integer[i*INT_WIDTH +: INT_WIDTH] =
      (k == KW'(NUM_BOOL + i)) ? proposals[i*INT_WIDTH +: INT_WIDTH]
                               : current_integer[i*INT_WIDTH +: INT_WIDTH];
  end

endmodule
`default_nettype wire

// File: rtl/gain_collector.sv
`default_nettype none
//------------------------------------------------------------------------------
// gain_collector : issues one candidate per variable, counts satisfied clauses
// Rev 1.0 ; optional GAIN_COLLECTOR_EARLY_EXIT_EN stops on a perfect gain
//------------------------------------------------------------------------------
module gain_collector
  import gain_collector_pkg::*;
#(
  parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = NI_W,
  parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = NB_W,
  parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE       = INT_W,
  parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE       = BOOL_W,
  parameter int MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX          = NC_W,
  localparam int C_NI = 1 << MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX,
  localparam int C_NB = 1 << MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX,
  localparam int C_CW = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX,
  localparam int C_NC = 1 << C_CW,
  localparam int C_GW = C_CW + 1,
  localparam int C_IW = MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE * C_NI,
  localparam int C_BW = MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE * C_NB,
  localparam int TOTAL_NUMBER_OF_VARIABLES = C_NB + C_NI,
  localparam int C_T  = TOTAL_NUMBER_OF_VARIABLES,
  localparam int C_KW = (C_T > 1) ? $clog2(C_T) : 1
) (
  input  wire logic                 in_clk,
  input  wire logic                 in_reset,
  input  wire logic                 in_start,
  input  wire logic [C_IW-1:0]      in_current_integer_assignment,
  input  wire logic [C_BW-1:0]      in_current_boolean_assignment,
  input  wire logic [C_IW-1:0]      in_integer_proposals,
  gain_collector_if.master          eval,
  output logic      [C_T*C_GW-1:0]  out_gains,
  output logic      [C_T*C_IW-1:0]  out_integer_assignments,
  output logic      [C_T*C_BW-1:0]  out_boolean_assignments,
  output logic                      out_busy,
  output logic                      out_valid
);

  state_t            r_state, w_state_next;
  logic [C_KW-1:0]   r_k;
  logic [C_CW-1:0]   r_beat;
  logic [C_GW-1:0]   r_count;
  logic [C_IW-1:0]   r_cur_int, r_proposals, r_eval_int;
  logic [C_BW-1:0]   r_cur_bool, r_eval_bool;
  logic              r_eval_valid;

  logic              w_start_ok, w_handshake, w_beat_in, w_last_beat, w_stop;
  logic [C_GW-1:0]   w_count_final;
  logic [C_KW-1:0]   w_build_k;
  logic [C_IW-1:0]   w_build_int, w_build_prop, w_cand_int;
  logic [C_BW-1:0]   w_build_bool, w_cand_bool;

  assign w_start_ok    = in_start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_handshake   = (r_state == ST_ISSUE) && r_eval_valid && eval.eval_ready;
  assign w_beat_in     = (r_state == ST_COLLECT) && eval.clause_valid;
  assign w_count_final = r_count + C_GW'(eval.clause_satisfied);
  assign w_last_beat   = w_beat_in && (r_beat == C_CW'(C_NC - 1));

`ifdef GAIN_COLLECTOR_EARLY_EXIT_EN
  assign w_stop = (r_k == C_KW'(C_T - 1)) || (w_count_final == C_GW'(C_NC));
`else
  assign w_stop = (r_k == C_KW'(C_T - 1));
`endif

  // The next candidate is registered one cycle ahead, so a round start must
  // build from the input ports rather than the not-yet-latched copies.
  always_comb begin
    w_build_k    = r_k + C_KW'(1);
    w_build_int  = r_cur_int;
    w_build_bool = r_cur_bool;
    w_build_prop = r_proposals;
    if (w_start_ok) begin
      w_build_k    = '0;
      w_build_int  = in_current_integer_assignment;
      w_build_bool = in_current_boolean_assignment;
      w_build_prop = in_integer_proposals;
    end
  end

  gain_collector_candidate_builder #(
    .NUM_BOOL   (C_NB),
    .NUM_INT    (C_NI),
    .INT_WIDTH  (MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE),
    .BOOL_WIDTH (MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE),
    .KW         (C_KW)
  ) u_builder (
    .k                 (w_build_k),
    .current_integer   (w_build_int),
    .current_boolean   (w_build_bool),
    .proposals         (w_build_prop),
    .candidate_integer (w_cand_int),
    .candidate_boolean (w_cand_bool)
  );

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) r_state <= ST_IDLE;
    else           r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (in_start)    w_state_next = ST_ISSUE;
      ST_ISSUE:         if (w_handshake) w_state_next = ST_COLLECT;
      ST_COLLECT:       if (w_last_beat) w_state_next = w_stop ? ST_DONE : ST_ISSUE;
      default:          w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      r_k                     <= '0;
      r_beat                  <= '0;
      r_count                 <= '0;
      r_cur_int               <= '0;
      r_cur_bool              <= '0;
      r_proposals             <= '0;
      r_eval_valid            <= 1'b0;
      r_eval_int              <= '0;
      r_eval_bool             <= '0;
      out_gains               <= '0;
      out_integer_assignments <= '0;
      out_boolean_assignments <= '0;
      out_valid               <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_cur_int               <= in_current_integer_assignment;
        r_cur_bool              <= in_current_boolean_assignment;
        r_proposals             <= in_integer_proposals;
        r_k                     <= '0;
        out_gains               <= '0;
        out_integer_assignments <= {C_T{in_current_integer_assignment}};
        out_boolean_assignments <= {C_T{in_current_boolean_assignment}};
        out_valid               <= 1'b0;
        r_eval_valid            <= 1'b1;
        r_eval_int              <= w_cand_int;
        r_eval_bool             <= w_cand_bool;
      end
      if (w_handshake) begin
        r_eval_valid <= 1'b0;
        r_count      <= '0;
        r_beat       <= '0;
      end
      if (w_beat_in) begin
        r_count <= w_count_final;
        r_beat  <= r_beat + C_CW'(1);
        if (w_last_beat) begin
          out_gains[r_k*C_GW +: C_GW]               <= w_count_final;
          out_integer_assignments[r_k*C_IW +: C_IW] <= r_eval_int;
          out_boolean_assignments[r_k*C_BW +: C_BW] <= r_eval_bool;
          if (w_stop) begin
            out_valid <= 1'b1;
          end else begin
            r_k          <= r_k + C_KW'(1);
            r_eval_valid <= 1'b1;
            r_eval_int   <= w_cand_int;
            r_eval_bool  <= w_cand_bool;
          end
        end
      end
    end
  end

  assign eval.eval_valid              = r_eval_valid;
  assign eval.eval_integer_assignment = r_eval_int;
  assign eval.eval_boolean_assignment = r_eval_bool;
  assign out_busy = (r_state == ST_ISSUE) || (r_state == ST_COLLECT);

endmodule
`default_nettype wire
